// File: rtl/mem_access.sv
// Memory-access stage of the multi-cycle core.
// It runs at most one data-memory word access per accepted enable and hands
// wselector/pc/data/rd to write-back with a one-cycle done pulse.
// A misaligned address or a memory timeout raises err and forces wselector
// to 000, which suppresses the register write.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [31:0] addr,
  input  logic [31:0] sdata,
  input  logic [31:0] result,
  input  logic [31:0] pc_in,
  input  logic [2:0]  wsel_in,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        done,
  output logic [2:0]  wselector,
  output logic [31:0] pc,
  output logic [31:0] data,
  output logic [4:0]  rd,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Last counter value before the access is abandoned.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

  // True for the two modes that touch memory (load word, store word).
  function automatic logic is_mem_mode(input logic [1:0] m);
    return (m == 2'b01) || (m == 2'b10);
  endfunction

  // Word accesses need the two low address bits clear.
  function automatic logic is_misaligned(input logic [31:0] a);
    return (a[1:0] != 2'b00);
  endfunction

  state_t      state_r,     state_s;
  logic [15:0] cnt_r,       cnt_s;
  logic        mem_req_r,   mem_req_s;
  logic        mem_we_r,    mem_we_s;
  logic [31:0] mem_addr_r,  mem_addr_s;
  logic [31:0] mem_wdata_r, mem_wdata_s;
  logic        done_r,      done_s;
  logic [2:0]  wsel_r,      wsel_s;
  logic [31:0] pc_r,        pc_s;
  logic [31:0] data_r,      data_s;
  logic [4:0]  rd_r,        rd_s;
  logic        err_r,       err_s;

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    done_s      = 1'b0;
    wsel_s      = wsel_r;
    pc_s        = pc_r;
    data_s      = data_r;
    rd_s        = rd_r;
    err_s       = err_r;

    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          pc_s   = pc_in;
          wsel_s = wsel_in;
          rd_s   = rd_in;
          err_s  = 1'b0;
          if (!is_mem_mode(mode)) begin
            data_s  = result;
            state_s = ST_FIN;
          end else if (is_misaligned(addr)) begin
            err_s   = 1'b1;
            wsel_s  = 3'b000;
            state_s = ST_FIN;
          end else begin
            mem_req_s   = 1'b1;
            mem_we_s    = mode[1];
            mem_addr_s  = addr;
            mem_wdata_s = sdata;
            cnt_s       = 16'd0;
            state_s     = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // An ack on the expiry cycle still counts as a normal completion.
        if (mem_ack) begin
          mem_req_s = 1'b0;
          mem_we_s  = 1'b0;
          if (mem_we_r) begin
            data_s = result;
          end else begin
            data_s = mem_rdata;
          end
          state_s = ST_FIN;
        end else if (cnt_r == CNT_LAST) begin
          mem_req_s = 1'b0;
          mem_we_s  = 1'b0;
          err_s     = 1'b1;
          wsel_s    = 3'b000;
          state_s   = ST_FIN;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end

      ST_FIN: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end

      default: begin
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      done_r      <= 1'b0;
      wsel_r      <= 3'b000;
      pc_r        <= 32'd0;
      data_r      <= 32'd0;
      rd_r        <= 5'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      done_r      <= done_s;
      wsel_r      <= wsel_s;
      pc_r        <= pc_s;
      data_r      <= data_s;
      rd_r        <= rd_s;
      err_r       <= err_s;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign done      = done_r;
  assign wselector = wsel_r;
  assign pc        = pc_r;
  assign data      = data_r;
  assign rd        = rd_r;
  assign err       = err_r;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, randomized
// operations against a rule-level reference model, and hand-written
// sequences for busy enables, mid-access reset and stray acks.
module tb_mem_access;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [1:0]  mode;
  logic [31:0] addr, sdata, result, pc_in;
  logic [2:0]  wsel_in;
  logic [4:0]  rd_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        done;
  logic [2:0]  wselector;
  logic [31:0] pc, data;
  logic [4:0]  rd;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_data;

  mem_access #(.TIMEOUT(T)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .mode(mode), .addr(addr),
    .sdata(sdata), .result(result), .pc_in(pc_in), .wsel_in(wsel_in),
    .rd_in(rd_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .done(done), .wselector(wselector), .pc(pc), .data(data), .rd(rd),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  m;
    logic [31:0] a, sd, res, p;
    logic [2:0]  ws;
    logic [4:0]  r;
    int          ackd;      // ack on this mem_req cycle; 0 = never
    logic [31:0] rdat;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [2:0]  exp_wsel;
    int          exp_lat;   // cycles after the enable edge until done
    int          exp_req;   // cycles with mem_req high
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_done"},    {31'd0, done},    32'd0);
    check({tag, "_data"},    data,             32'd0);
    check({tag, "_pc"},      pc,               32'd0);
    check({tag, "_misc"},    {20'd0, mem_we, wselector, rd, err, 2'd0}, 32'd0);
    check({tag, "_bus"},     mem_addr | mem_wdata, 32'd0);
  endtask

  // One enable pulse plus memory responder; checks the whole transaction.
  task automatic run_op(input vec_t v);
    int cyc, reqcnt, busbad;
    logic [31:0] junk;
    @(negedge clk);
    mode = v.m; addr = v.a; sdata = v.sd; result = v.res;
    pc_in = v.p; wsel_in = v.ws; rd_in = v.r; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    cyc = 0; reqcnt = 0; busbad = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (mem_req === 1'b1) begin
        reqcnt++;
        if (mem_addr !== v.a || mem_we !== v.m[1] || (v.m[1] && mem_wdata !== v.sd))
          busbad++;
        junk = $urandom;
        mem_ack   = (reqcnt == v.ackd);
        mem_rdata = (reqcnt == v.ackd) ? v.rdat : junk;
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency",   cyc,          v.exp_lat);
    check("req_cycles", reqcnt,      v.exp_req);
    check("bus_stable", busbad,      0);
    check("data",      data,         v.exp_data);
    check("err",       {31'd0, err}, {31'd0, v.exp_err});
    check("wselector", {29'd0, wselector}, {29'd0, v.exp_wsel});
    check("pc",        pc,           v.p);
    check("rd",        {27'd0, rd},  {27'd0, v.r});
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("data_hold",  data,          v.exp_data);
    model_data = v.exp_data;
  endtask

  // Reference model: derive expectations from the access rules.
  function automatic vec_t predict(input vec_t v, input logic [31:0] prev);
    vec_t o = v;
    logic is_mem, mis, tmo;
    is_mem = (v.m == 2'b01) || (v.m == 2'b10);
    mis    = is_mem && (v.a % 4 != 0);
    tmo    = is_mem && !mis && (v.ackd == 0 || v.ackd > T);
    o.exp_err  = mis || tmo;
    o.exp_wsel = o.exp_err ? 3'b000 : v.ws;
    if (!is_mem)          o.exp_data = v.res;
    else if (o.exp_err)   o.exp_data = prev;
    else if (v.m == 2'b01) o.exp_data = v.rdat;
    else                  o.exp_data = v.res;
    if (!is_mem || mis) begin o.exp_lat = 1;         o.exp_req = 0;      end
    else if (tmo)       begin o.exp_lat = T + 1;     o.exp_req = T;      end
    else                begin o.exp_lat = v.ackd + 1; o.exp_req = v.ackd; end
    return o;
  endfunction

  initial begin
    int dones, reqs;
    vec_t v;
    logic [31:0] rnd;

    rstn = 1'b0; enable = 1'b0; mode = 2'b00; addr = 32'd0; sdata = 32'd0;
    result = 32'd0; pc_in = 32'd0; wsel_in = 3'd0; rd_in = 5'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0; model_data = 32'd0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rstn = 1'b1;

    tbl[0] = '{2'b00, 32'h0,   32'h0,        32'h1234,     32'h40, 3'b010, 5'd5,  0, 32'h0,        1'b0, 32'h1234,     3'b010, 1, 0};
    tbl[1] = '{2'b01, 32'h100, 32'h0,        32'h9,        32'h44, 3'b001, 5'd7,  3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 3'b001, 4, 3};
    tbl[2] = '{2'b10, 32'h200, 32'hA5A5A5A5, 32'h55,       32'h48, 3'b000, 5'd0,  2, 32'h11111111, 1'b0, 32'h55,       3'b000, 3, 2};
    tbl[3] = '{2'b01, 32'h102, 32'h0,        32'h66,       32'h4C, 3'b010, 5'd9,  1, 32'h22,       1'b1, 32'h55,       3'b000, 1, 0};
    tbl[4] = '{2'b01, 32'h300, 32'h0,        32'h77,       32'h50, 3'b011, 5'd10, 0, 32'h33,       1'b1, 32'h55,       3'b000, 5, 4};
    tbl[5] = '{2'b01, 32'h304, 32'h0,        32'h88,       32'h54, 3'b100, 5'd11, 4, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 3'b100, 5, 4};
    tbl[6] = '{2'b11, 32'h0,   32'h0,        32'hCAFEF00D, 32'h58, 3'b101, 5'd31, 0, 32'h0,        1'b0, 32'hCAFEF00D, 3'b101, 1, 0};
    tbl[7] = '{2'b10, 32'h201, 32'h12345678, 32'h99,       32'h5C, 3'b110, 5'd1,  1, 32'h0,        1'b1, 32'hCAFEF00D, 3'b000, 1, 0};
    tbl[8] = '{2'b10, 32'h208, 32'h87654321, 32'hAA,       32'h60, 3'b111, 5'd2,  5, 32'h0,        1'b1, 32'hCAFEF00D, 3'b000, 5, 4};

    for (int i = 0; i < 9; i++) run_op(tbl[i]);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.m    = 2'($urandom_range(0, 3));
      rnd    = $urandom;
      v.a    = {rnd[31:2], 2'b00};
      if ($urandom_range(0, 3) == 0) v.a[1:0] = 2'($urandom_range(1, 3));
      v.sd   = $urandom;
      v.res  = $urandom;
      v.p    = $urandom;
      v.ws   = 3'($urandom_range(0, 7));
      v.r    = 5'($urandom_range(0, 31));
      v.ackd = $urandom_range(0, T + 2);
      v.rdat = $urandom;
      run_op(predict(v, model_data));
    end

    // Second enable during WAIT is ignored: exactly one done.
    @(negedge clk);
    mode = 2'b01; addr = 32'h400; pc_in = 32'h70; wsel_in = 3'b001; rd_in = 5'd3;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    dones = 0; reqs = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) begin
        enable = 1'b1; mode = 2'b00; result = 32'h777; pc_in = 32'h99;
      end else begin
        enable = 1'b0;
      end
      if (mem_req === 1'b1) begin
        reqs++;
        mem_ack   = (reqs == 3);
        mem_rdata = 32'h13579BDF;
      end else begin
        mem_ack = 1'b0;
      end
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check("busy_done_count", dones, 1);
    check("busy_data", data, 32'h13579BDF);
    check("busy_pc", pc, 32'h70);

    // Reset during WAIT abandons the access; stray acks in IDLE are ignored.
    @(negedge clk);
    mode = 2'b01; addr = 32'h500; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("wait_req_before_reset", {31'd0, mem_req}, 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check_zero_outputs("midreset");
    rstn = 1'b1;
    dones = 0; reqs = 0;
    for (int c = 0; c < 10; c++) begin
      mem_ack = (c % 2 == 0);
      mem_rdata = 32'hFFFF0000;
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (mem_req === 1'b1) reqs++;
    end
    mem_ack = 1'b0;
    check("post_reset_no_done", dones, 0);
    check("post_reset_no_req", reqs, 0);
    model_data = 32'd0;

    v = '{2'b00, 32'h0, 32'h0, 32'h31415926, 32'h80, 3'b011, 5'd12, 0, 32'h0, 1'b0, 32'h0, 3'b0, 0, 0};
    run_op(predict(v, model_data));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the multi-cycle core. Sits between execute and write-back.
- Takes the execute result and load/store command, runs one word access on the data-memory handshake, and presents wselector/pc/data/rd to write-back.
- Pulses done when its outputs are valid.
- Reports misaligned accesses and memory timeouts, and suppresses write-back when either occurs.

Parameters:
- TIMEOUT, 255: cycles with mem_req high and no mem_ack before the access is aborted (1..65535).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- enable  in  1  one-cycle start pulse from execute
- mode  in  2  00 = pass-through, 01 = load word, 10 = store word, 11 = pass-through
- addr  in  32  byte address (execute result for loads/stores)
- sdata  in  32  store data
- result  in  32  execute result forwarded on pass-through
- pc_in  in  32  next pc from execute
- wsel_in  in  3  write-back selector from execute
- rd_in  in  5  destination register
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid when mem_ack = 1
- mem_ack  in  1  one-cycle acknowledge
- done  out  1  one-cycle pulse: outputs below are valid
- wselector  out  3  forwarded wsel_in, forced to 000 on error
- pc  out  32  latched pc_in
- data  out  32  load data or result
- rd  out  5  latched rd_in
- err  out  1  valid with done: 1 = misaligned or timeout

Behaviour:
- Reset (rstn = 0 at a clk edge): state goes to IDLE. All outputs go to 0: mem_req, mem_we, mem_addr, mem_wdata, done, wselector, pc, data, rd, err. The timeout counter clears. Reset mid-access abandons the access; no done is produced.
- States: IDLE, WAIT, FIN.
- IDLE, enable = 1:
  - Latch pc_in, wsel_in and rd_in into pc, wselector and rd. Clear err.
  - Pass-through modes: data <= result; go to FIN.
  - Load/store with addr[1:0] != 0: err <= 1, wselector <= 000; go to FIN. No memory request.
  - Load/store, aligned: mem_req <= 1, mem_we <= mode[1], mem_addr <= addr, mem_wdata <= sdata, counter <= 0; go to WAIT.
- WAIT:
  - mem_ack = 1: mem_req <= 0, mem_we <= 0. Load: data <= mem_rdata. Store: data <= result. Go to FIN.
  - Else, counter == TIMEOUT-1: mem_req <= 0, err <= 1, wselector <= 000; go to FIN.
  - Else counter increments.
  - mem_addr and mem_wdata stay stable while mem_req = 1.
- FIN: done <= 1 for exactly one cycle, then IDLE. wselector, pc, data, rd and err hold their values until the next enable is accepted.
- Latency, measured from the edge that samples enable to done high:
  - pass-through and misaligned: 2 edges;
  - memory: ack sampled at edge k gives done high after edge k+1.
- enable while not in IDLE is ignored. No queueing.
- mem_ack while in IDLE or FIN is ignored.
- mem_ack arriving on the same edge the timeout expires: the ack wins (normal completion, err = 0).
- done never asserts without a preceding accepted enable.

Test Plan:
- Pass-through: mode = 00, result = 0x1234, wsel_in = 010, rd_in = 5, pc_in = 0x40 → done 2 edges later, data = 0x1234, wselector = 010, rd = 5, pc = 0x40, err = 0, mem_req never high.
- Load: mode = 01, addr = 0x100; memory acks after 3 cycles with rdata = 0xDEADBEEF → mem_req high for 3 cycles with mem_addr = 0x100 and mem_we = 0; done one cycle after ack; data = 0xDEADBEEF.
- Store: mode = 10, addr = 0x200, sdata = 0xA5A5A5A5, wsel_in = 000 → mem_we = 1, mem_wdata = 0xA5A5A5A5 while mem_req high; single done pulse, err = 0.
- Misaligned: mode = 01, addr = 0x102, wsel_in = 010 → no mem_req; done 2 edges later with err = 1, wselector = 000.
- Timeout: TIMEOUT = 4, load, never ack → mem_req high exactly 4 cycles then low; done with err = 1, wselector = 000. Repeat with ack on the 4th cycle → err = 0.
- Busy and reset: second enable during WAIT is ignored (exactly one done). rstn low during WAIT → mem_req low after that edge, no done; a following enable works normally.
